// File: rtl/bip_pkg.sv
// Shared definitions for the BIP instruction set: word layout, opcodes and loader FSM states.
// Used by the program loader and by the instruction decoder.
package bip_pkg;

  localparam int OPCODE_W  = 5;
  localparam int OPERAND_W = 11;
  localparam int INSTR_W   = OPCODE_W + OPERAND_W;

  localparam logic [OPCODE_W-1:0] HLT  = 5'b00000;
  localparam logic [OPCODE_W-1:0] LDA  = 5'b00001;
  localparam logic [OPCODE_W-1:0] STA  = 5'b00010;
  localparam logic [OPCODE_W-1:0] ADD  = 5'b00011;
  localparam logic [OPCODE_W-1:0] SUB  = 5'b00100;
  localparam logic [OPCODE_W-1:0] LDI  = 5'b00101;
  localparam logic [OPCODE_W-1:0] ADDI = 5'b00110;
  localparam logic [OPCODE_W-1:0] SUBI = 5'b00111;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_WAIT_HI,
    LD_WAIT_LO,
    LD_WRITE,
    LD_DONE
  } loader_state_e;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPCODE_W];
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Byte-pair latch for the program loader: the high byte arrives first, then the low byte.
// word_valid_o strobes combinationally in the cycle the low byte is accepted.
module word_assembler
  import bip_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear_i,
  input  logic               byte_valid_i,
  input  logic [7:0]         byte_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               word_valid_o
);

  logic [7:0] hi_q, hi_d;
  logic [7:0] lo_q, lo_d;
  logic       lo_next_q, lo_next_d;

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    lo_next_d = lo_next_q;
    if (clear_i) begin
      hi_d      = 8'h00;
      lo_d      = 8'h00;
      lo_next_d = 1'b0;
    end else if (byte_valid_i) begin
      if (lo_next_q) lo_d = byte_i;
      else           hi_d = byte_i;
      lo_next_d = ~lo_next_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q      <= 8'h00;
      lo_q      <= 8'h00;
      lo_next_q <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      lo_next_q <= lo_next_d;
    end
  end

  assign word_o       = {hi_q, lo_q};
  assign word_valid_o = byte_valid_i && lo_next_q && !clear_i;

endmodule

// File: rtl/program_loader.sv
// Program-memory writer: assembles UART byte pairs into instruction words and holds the CPU in reset
// until an HLT word is stored. Define OPCODE_CHECK_EN to reject words with opcodes above SUBI.
module program_loader
  import bip_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int MEM_DEPTH = 2048
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_done,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_rst,
  output logic               busy,
  output logic               done,
  output logic               err_overflow,
`ifdef OPCODE_CHECK_EN
  output logic               err_opcode,
`endif
  output logic [ADDR_W:0]    word_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(MEM_DEPTH);

  loader_state_e        state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W:0]      count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 asm_clear, byte_accept, word_valid;
  logic [INSTR_W-1:0]   word;
  logic                 is_hlt, at_last, rejected, err_any;

  word_assembler u_word_assembler (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear_i      (asm_clear),
    .byte_valid_i (byte_accept),
    .byte_i       (rx_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  assign is_hlt  = (opcode_of(word) == HLT);
  assign at_last = (addr_q == LAST_ADDR);

`ifdef OPCODE_CHECK_EN
  logic opc_err_q, opc_err_d;

  assign rejected   = (opcode_of(word) > SUBI);
  assign err_any    = ovf_q | opc_err_q;
  assign err_opcode = opc_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) opc_err_q <= 1'b0;
    else          opc_err_q <= opc_err_d;
  end
`else
  assign rejected = 1'b0;
  assign err_any  = ovf_q;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
`ifdef OPCODE_CHECK_EN
    opc_err_d   = opc_err_q;
`endif
    asm_clear   = 1'b0;
    byte_accept = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      LD_IDLE, LD_DONE: begin
        if (start) begin
          state_d   = LD_WAIT_HI;
          addr_d    = '0;
          count_d   = '0;
          ovf_d     = 1'b0;
`ifdef OPCODE_CHECK_EN
          opc_err_d = 1'b0;
`endif
          asm_clear = 1'b1;
        end
      end
      LD_WAIT_HI: begin
        if (rx_done) begin
          byte_accept = 1'b1;
          state_d     = LD_WAIT_LO;
        end
      end
      LD_WAIT_LO: begin
        byte_accept = rx_done;
        if (word_valid) state_d = LD_WRITE;
      end
      LD_WRITE: begin
        if (rejected) begin
`ifdef OPCODE_CHECK_EN
          opc_err_d = 1'b1;
`endif
          state_d = LD_DONE;
        end else begin
          mem_we = 1'b1;
          // The address holds at the last slot so it never wraps past the memory.
          if (!at_last)              addr_d  = addr_q + 1'b1;
          if (count_q != DEPTH_CNT)  count_d = count_q + 1'b1;
          if (is_hlt) begin
            state_d = LD_DONE;
          end else if (at_last) begin
            ovf_d   = 1'b1;
            state_d = LD_DONE;
          end else if (rx_done) begin
            byte_accept = 1'b1;
            state_d     = LD_WAIT_LO;
          end else begin
            state_d = LD_WAIT_HI;
          end
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LD_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign mem_addr     = addr_q;
  assign mem_wdata    = word;
  assign busy         = (state_q == LD_WAIT_HI) || (state_q == LD_WAIT_LO) || (state_q == LD_WRITE);
  assign done         = (state_q == LD_DONE);
  assign err_overflow = ovf_q;
  assign word_count   = count_q;
  assign cpu_rst      = !(done && !err_any);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized load sessions
// checked against a word-list model of the loader. Honours OPCODE_CHECK_EN when defined.
module tb_program_loader;

  localparam int TB_ADDR_W = 2;
  localparam int TB_DEPTH  = 4;

  logic                 clk;
  logic                 reset_n;
  logic                 start;
  logic [7:0]           rx_data;
  logic                 rx_done;
  logic                 mem_we;
  logic [TB_ADDR_W-1:0] mem_addr;
  logic [15:0]          mem_wdata;
  logic                 cpu_rst;
  logic                 busy;
  logic                 done;
  logic                 err_overflow;
`ifdef OPCODE_CHECK_EN
  logic                 err_opcode;
`endif
  logic [TB_ADDR_W:0]   word_count;

  int nAsserts = 0;
  int nFails   = 0;

  logic [15:0]          prog    [0:7];
  bit                   expWe   [0:7];
  logic [15:0]          expData [0:7];
  logic [TB_ADDR_W-1:0] wrAddr  [$];
  logic [15:0]          wrData  [$];

  program_loader #(
    .ADDR_W    (TB_ADDR_W),
    .MEM_DEPTH (TB_DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .done         (done),
    .err_overflow (err_overflow),
`ifdef OPCODE_CHECK_EN
    .err_opcode   (err_opcode),
`endif
    .word_count   (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory-side monitor: every write the DUT performs is recorded for the end-of-session check.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wrAddr.push_back(mem_addr);
      wrData.push_back(mem_wdata);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic idle(input int cycles, input bit noise);
    repeat (cycles) begin
      start = noise && ($urandom_range(0, 2) == 0);
      tick();
      start = 1'b0;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_we"},    32'(mem_we),       32'd0);
    checkOutput({tag, "_addr"},  32'(mem_addr),     32'd0);
    checkOutput({tag, "_wdata"}, 32'(mem_wdata),    32'd0);
    checkOutput({tag, "_cpurst"},32'(cpu_rst),      32'd1);
    checkOutput({tag, "_busy"},  32'(busy),         32'd0);
    checkOutput({tag, "_done"},  32'(done),         32'd0);
    checkOutput({tag, "_ovf"},   32'(err_overflow), 32'd0);
    checkOutput({tag, "_count"}, 32'(word_count),   32'd0);
`ifdef OPCODE_CHECK_EN
    checkOutput({tag, "_opcerr"},32'(err_opcode),   32'd0);
`endif
  endtask

  // Runs one load session of prog[0..n-1]; forceFast sends every next high byte in the WRITE cycle.
  task automatic applyStimulus(input int n, input bit forceFast, input bit noise);
    int  k;
    int  lastI;
    int  g;
    bit  ovf;
    bit  opc;
    bit  term;
    bit  hiSent;
    int  widx;
    logic [4:0] op;

    k = 0; ovf = 0; opc = 0; term = 0; lastI = n - 1;
    for (int i = 0; i < n && !term; i++) begin
      op       = prog[i][15:11];
      expWe[i] = 1'b0;
`ifdef OPCODE_CHECK_EN
      if (op > 5'd7) begin
        opc   = 1;
        term  = 1;
        lastI = i;
        continue;
      end
`endif
      expWe[i]   = 1'b1;
      expData[k] = prog[i];
      k++;
      if (op == 5'd0) begin
        term  = 1;
        lastI = i;
      end else if (i == TB_DEPTH - 1) begin
        ovf   = 1;
        term  = 1;
        lastI = i;
      end
    end

    wrAddr.delete();
    wrData.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("start_busy",   32'(busy),       32'd1);
    checkOutput("start_done",   32'(done),       32'd0);
    checkOutput("start_cpurst", 32'(cpu_rst),    32'd1);
    checkOutput("start_count",  32'(word_count), 32'd0);
    checkOutput("start_ovf",    32'(err_overflow), 32'd0);

    hiSent = 0;
    widx   = 0;
    if (!forceFast) idle($urandom_range(0, 2), noise);
    for (int i = 0; i <= lastI; i++) begin
      if (!hiSent) sendByte(prog[i][15:8]);
      if (!forceFast) idle($urandom_range(0, 2), noise);
      sendByte(prog[i][7:0]);
      checkOutput($sformatf("we_w%0d", i), 32'(mem_we), 32'(expWe[i]));
      if (expWe[i]) begin
        checkOutput($sformatf("addr_w%0d", i),  32'(mem_addr),  32'(widx));
        checkOutput($sformatf("wdata_w%0d", i), 32'(mem_wdata), 32'(prog[i]));
        widx++;
      end
      hiSent = 0;
      if (i == lastI) begin
        checkOutput("cpurst_write", 32'(cpu_rst), 32'd1);
      end else begin
        g = forceFast ? 0 : $urandom_range(0, 2);
        if (g == 0) begin
          sendByte(prog[i+1][15:8]);
          hiSent = 1;
        end else begin
          idle(g, noise);
        end
      end
    end

    tick();
    checkOutput("end_done",   32'(done),         32'd1);
    checkOutput("end_busy",   32'(busy),         32'd0);
    checkOutput("end_ovf",    32'(err_overflow), 32'(ovf));
    checkOutput("end_cpurst", 32'(cpu_rst),      32'(ovf || opc));
    checkOutput("end_count",  32'(word_count),   32'(k));
    checkOutput("end_addr",   32'(mem_addr),     32'((k == TB_DEPTH) ? TB_DEPTH - 1 : k));
`ifdef OPCODE_CHECK_EN
    checkOutput("end_opcerr", 32'(err_opcode),   32'(opc));
`endif
    checkOutput("end_nwrites", 32'(wrAddr.size()), 32'(k));
    for (int j = 0; j < k && j < wrAddr.size(); j++) begin
      checkOutput($sformatf("mem_addr_%0d", j), 32'(wrAddr[j]), 32'(j));
      checkOutput($sformatf("mem_data_%0d", j), 32'(wrData[j]), 32'(expData[j]));
    end
  endtask

  initial begin
    int   len;
    logic [4:0] op;

    reset_n = 1'b0;
    start   = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    #12;
    checkResetValues("reset");
    reset_n = 1'b1;
    tick();
    checkResetValues("idle");

    $display("[TB] bytes before start are ignored, then a two-word program");
    sendByte(8'h33);
    sendByte(8'h44);
    tick();
    checkOutput("prestart_busy",    32'(busy),          32'd0);
    checkOutput("prestart_nwrites", 32'(wrAddr.size()), 32'd0);
    prog[0] = 16'h1805;
    prog[1] = 16'h0000;
    applyStimulus(2, 0, 0);

    $display("[TB] overflow with four non-HLT words");
    for (int i = 0; i < 4; i++) prog[i] = 16'h2001;
    applyStimulus(4, 0, 0);

    $display("[TB] next high byte arrives during WRITE");
    prog[0] = 16'h1805;
    prog[1] = 16'h2A07;
    prog[2] = 16'h0000;
    applyStimulus(3, 1, 0);

    $display("[TB] reset in the middle of a session");
    wrAddr.delete();
    wrData.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    sendByte(8'h18);
    sendByte(8'h05);
    tick();
    sendByte(8'h20);
    checkOutput("mid_busy",  32'(busy),       32'd1);
    checkOutput("mid_count", 32'(word_count), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    checkResetValues("midreset");
    checkOutput("mid_nwrites", 32'(wrAddr.size()), 32'd1);
    #2;
    reset_n = 1'b1;
    tick();
    prog[0] = 16'h1805;
    prog[1] = 16'h0000;
    applyStimulus(2, 0, 0);

`ifdef OPCODE_CHECK_EN
    $display("[TB] illegal opcode at position 1");
    prog[0] = 16'h1805;
    prog[1] = 16'h4000;
    applyStimulus(2, 0, 0);
`endif

    $display("[TB] randomized sessions");
    for (int s = 0; s < 24; s++) begin
      len = $urandom_range(1, TB_DEPTH);
      for (int j = 0; j < len; j++) begin
`ifdef OPCODE_CHECK_EN
        op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(1, 7));
`else
        op = 5'($urandom_range(1, 31));
`endif
        prog[j] = {op, 11'($urandom)};
      end
      if (len < TB_DEPTH || $urandom_range(0, 1) == 1)
        prog[len-1] = {5'd0, 11'($urandom)};
      applyStimulus(len, ($urandom_range(0, 3) == 0), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
